// File: rtl/nibble_acc_pkg.sv
// Purpose : shared field positions, FSM state type and width helper for the nibble accumulator.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package nibble_acc_pkg;

  // Bit positions of the fields inside one incoming nibble {a, c[1:0], b}.
  localparam int A_BIT = 3;
  localparam int C_MSB = 2;
  localparam int C_LSB = 1;
  localparam int B_BIT = 0;

  // FILL: assembling a word. FULL: a complete word waits for the output register.
  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } acc_state_e;

  // Width of the regrouped output word for a given number of nibbles.
  function automatic int out_word_width(input int depth);
    return 4 * depth;
  endfunction

endpackage

// File: rtl/nibble_regroup.sv
// Purpose : regroups DEPTH packed nibbles into {out_a, out_c, out_b} by field kind.
// Latency : purely combinational, zero cycles.
// Backpressure: none; no state, no handshake.
//
// Ports:
//   nibbles  in   DEPTH x 4 assembly buffer, index 0 = first nibble accepted
//   word     out  {out_a[DEPTH-1:0], out_c[2*DEPTH-1:0], out_b[DEPTH-1:0]}
module nibble_regroup
  import nibble_acc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0][3:0]              nibbles,
  output logic [out_word_width(DEPTH)-1:0]   word
);

  logic [DEPTH-1:0]   out_a;
  logic [2*DEPTH-1:0] out_c;
  logic [DEPTH-1:0]   out_b;

  for (genvar i = 0; i < DEPTH; i++) begin : g_field
    assign out_a[i]         = nibbles[i][A_BIT];
    assign out_c[2*i +: 2]  = nibbles[i][C_MSB:C_LSB];
    assign out_b[i]         = nibbles[i][B_BIT];
  end

  assign word = {out_a, out_c, out_b};

endmodule

// File: rtl/nibble_field_accumulator.sv
// Purpose : collects DEPTH nibbles, regroups fields by kind, presents the word on valid/ready.
// Latency : out_valid/out_word update on the same edge that accepts the last nibble.
// Backpressure: one-word output register; if it is still occupied when a word completes, the
//               word waits in the assembly buffer (FULL) and in_ready drops until handoff.
//
// Optional feature: define NIBBLE_ACC_PARITY_EN to add the registered out_parity output.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid/in_ready    input handshake, in_nibble = {a, c[1:0], b}
//   out_valid/out_ready  output handshake, out_word = {out_a, out_c, out_b}
//   out_parity           XOR of all out_word bits (NIBBLE_ACC_PARITY_EN only)
module nibble_field_accumulator
  import nibble_acc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               in_valid,
  input  logic [3:0]                         in_nibble,
  output logic                               in_ready,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [out_word_width(DEPTH)-1:0]   out_word
`ifdef NIBBLE_ACC_PARITY_EN
  ,
  output logic                               out_parity
`endif
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WW = out_word_width(DEPTH);

  acc_state_e              state, state_nxt;
  logic [IW-1:0]           idx, idx_nxt;
  logic [DEPTH-1:0][3:0]   asm_buf, asm_buf_nxt;
  logic [WW-1:0]           word_nxt;

  logic accept;
  logic handoff;
  logic last;
  logic out_free;
  logic load;
  logic clr_valid;

  // in_ready depends only on state and rst so it never loops back through out_ready.
  assign in_ready = (state == FILL) && !rst;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid && out_ready;
  assign last     = accept && (idx == IW'(DEPTH - 1));
  assign out_free = !out_valid || out_ready;

  // Merge the nibble being accepted so the completing word is available on the same edge.
  always_comb begin
    asm_buf_nxt = asm_buf;
    if (accept) begin
      asm_buf_nxt[idx] = in_nibble;
    end
  end

  nibble_regroup #(
    .DEPTH (DEPTH)
  ) u_regroup (
    .nibbles (asm_buf_nxt),
    .word    (word_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    clr_valid = 1'b0;
    unique case (state)
      FILL: begin
        if (accept) begin
          idx_nxt = idx + 1'b1;
        end
        if (last) begin
          idx_nxt = '0;
          if (out_free) begin
            load = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end
        if (handoff && !load) begin
          clr_valid = 1'b1;
        end
      end
      FULL: begin
        // FULL is only entered with out_valid set, so out_ready alone means handoff.
        if (handoff) begin
          load      = 1'b1;
          state_nxt = FILL;
        end
      end
      default: begin
        state_nxt = FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      asm_buf <= '0;
    end else begin
      idx     <= idx_nxt;
      asm_buf <= asm_buf_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_word  <= word_nxt;
    end else if (clr_valid) begin
      out_valid <= 1'b0;
    end
  end

`ifdef NIBBLE_ACC_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (load) begin
      out_parity <= ^word_nxt;
    end
  end
`endif

endmodule
